// File: rtl/physical_freelist.sv
// physical_freelist
//
// Free list of physical destination registers for the rename/commit unit.
// Rename can take up to two unused registers per cycle from the head of a
// circular buffer. Commit can return up to two stale mappings per cycle at
// the tail. Every register handed out later becomes a writeback target in
// physical_regfile, so both blocks share REG_SIZE / REG_SIZE_WIDTH.
//
// Optional feature macro: FREELIST_DUP_CHECK_EN
//   When defined, a free bitmap tracks which registers are currently in the
//   list. A release of an already-free register (or the same register on
//   both release slots) is dropped and sets the sticky dup_err_o.
//   When undefined, dup_err_o is tied low and every non-p0 release is pushed.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   alloc_first_i/second_i    rename consumes the first/second offered reg
//   alloc_prd_first_o/second_o  registers offered at head / head+1
//   alloc_first_valid_o       at least one free register
//   alloc_second_valid_o      at least two free registers
//   release_first_i/_prd_i    first commit release slot
//   release_second_i/_prd_i   second commit release slot
//   free_count_o              number of free entries
//   overflow_err_o            sticky: a push was dropped because list was full
//   dup_err_o                 sticky: a duplicate release was detected

module physical_freelist #(
  parameter int REG_SIZE       = 48,
  parameter int REG_SIZE_WIDTH = 6,
  parameter int ARCH_REG_NUM   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_first_i,
  input  logic                      alloc_second_i,
  output logic [REG_SIZE_WIDTH-1:0] alloc_prd_first_o,
  output logic [REG_SIZE_WIDTH-1:0] alloc_prd_second_o,
  output logic                      alloc_first_valid_o,
  output logic                      alloc_second_valid_o,
  input  logic                      release_first_i,
  input  logic [REG_SIZE_WIDTH-1:0] release_first_prd_i,
  input  logic                      release_second_i,
  input  logic [REG_SIZE_WIDTH-1:0] release_second_prd_i,
  output logic [REG_SIZE_WIDTH:0]   free_count_o,
  output logic                      overflow_err_o,
  output logic                      dup_err_o
);

  localparam int INIT_FREE = REG_SIZE - ARCH_REG_NUM;
  localparam logic [REG_SIZE_WIDTH:0]   FULL_CNT  = (REG_SIZE_WIDTH+1)'(REG_SIZE);
  localparam logic [REG_SIZE_WIDTH:0]   INIT_CNT  = (REG_SIZE_WIDTH+1)'(INIT_FREE);
  localparam logic [REG_SIZE_WIDTH-1:0] INIT_TAIL = REG_SIZE_WIDTH'(INIT_FREE % REG_SIZE);
  localparam logic [REG_SIZE_WIDTH-1:0] LAST_PTR  = REG_SIZE_WIDTH'(REG_SIZE - 1);

  // REG_SIZE need not be a power of two, so wrap explicitly.
  function automatic logic [REG_SIZE_WIDTH-1:0] ptr_inc(input logic [REG_SIZE_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + REG_SIZE_WIDTH'(1);
  endfunction

  logic [REG_SIZE_WIDTH-1:0] buf_q [REG_SIZE];
  logic [REG_SIZE_WIDTH-1:0] buf_d [REG_SIZE];
  logic [REG_SIZE_WIDTH-1:0] head_q, head_d;
  logic [REG_SIZE_WIDTH-1:0] tail_q, tail_d;
  logic [REG_SIZE_WIDTH:0]   count_q, count_d;
  logic                      overflow_q, overflow_d;

  logic                      pop_first, pop_second;
  logic [REG_SIZE_WIDTH:0]   pop_cnt;
  logic                      first_dup, second_dup;
  logic                      rel_first_ok, rel_second_ok;
  logic                      push_first, push_second;
  logic                      ovf_first, ovf_second;
  logic [REG_SIZE_WIDTH:0]   after_pop, after_first;
  logic [REG_SIZE_WIDTH-1:0] second_wr_ptr;

  // Offered registers are plain reads at head/head+1, independent of requests.
  assign alloc_prd_first_o    = buf_q[head_q];
  assign alloc_prd_second_o   = buf_q[ptr_inc(head_q)];
  assign alloc_first_valid_o  = (count_q != '0);
  assign alloc_second_valid_o = (count_q > (REG_SIZE_WIDTH+1)'(1));
  assign free_count_o         = count_q;
  assign overflow_err_o       = overflow_q;

  // Accepted pops: the second slot only counts together with the first.
  always_comb begin
    pop_first  = alloc_first_i & alloc_first_valid_o;
    pop_second = alloc_second_i & alloc_first_i & alloc_second_valid_o;
    pop_cnt    = (REG_SIZE_WIDTH+1)'(pop_first) + (REG_SIZE_WIDTH+1)'(pop_second);
  end

  // Release qualification and capacity check. The first slot is pushed
  // before the second, and capacity is judged after this cycle's pops so a
  // full list can still accept a release in a cycle that also allocates.
  always_comb begin
    rel_first_ok  = release_first_i && (release_first_prd_i != '0) && !first_dup;
    rel_second_ok = release_second_i && (release_second_prd_i != '0) && !second_dup;
    after_pop     = count_q - pop_cnt;
    push_first    = rel_first_ok && (after_pop < FULL_CNT);
    ovf_first     = rel_first_ok && !(after_pop < FULL_CNT);
    after_first   = after_pop + (REG_SIZE_WIDTH+1)'(push_first);
    push_second   = rel_second_ok && (after_first < FULL_CNT);
    ovf_second    = rel_second_ok && !(after_first < FULL_CNT);
    second_wr_ptr = push_first ? ptr_inc(tail_q) : tail_q;
  end

  // Next state of buffer, pointers, count and overflow flag.
  always_comb begin
    buf_d      = buf_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = after_first + (REG_SIZE_WIDTH+1)'(push_second);
    overflow_d = overflow_q | ovf_first | ovf_second;

    if (pop_first) begin
      head_d = pop_second ? ptr_inc(ptr_inc(head_q)) : ptr_inc(head_q);
    end

    if (push_first) begin
      buf_d[tail_q] = release_first_prd_i;
    end
    if (push_second) begin
      buf_d[second_wr_ptr] = release_second_prd_i;
    end
    if (push_second) begin
      tail_d = ptr_inc(second_wr_ptr);
    end else if (push_first) begin
      tail_d = ptr_inc(tail_q);
    end

    if (rst) begin
      for (int i = 0; i < REG_SIZE; i++) begin
        buf_d[i] = (i < INIT_FREE) ? REG_SIZE_WIDTH'(ARCH_REG_NUM + i) : '0;
      end
      head_d     = '0;
      tail_d     = INIT_TAIL;
      count_d    = INIT_CNT;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    buf_q      <= buf_d;
    head_q     <= head_d;
    tail_q     <= tail_d;
    count_q    <= count_d;
    overflow_q <= overflow_d;
  end

`ifdef FREELIST_DUP_CHECK_EN
  logic [REG_SIZE-1:0] free_map_q, free_map_d;
  logic                dup_q, dup_d;

  // A set bit means the register is already in the list; releasing it again
  // is a duplicate. Both slots naming one register drops the second slot.
  always_comb begin
    first_dup  = release_first_i && (release_first_prd_i != '0) &&
                 free_map_q[release_first_prd_i];
    second_dup = release_second_i && (release_second_prd_i != '0) &&
                 (free_map_q[release_second_prd_i] ||
                  (release_first_i && (release_first_prd_i == release_second_prd_i)));
  end

  // Popped registers leave the list, pushed ones join it. A pushed register
  // never matches a popped one because popped bits are set and pushed are clear.
  always_comb begin
    free_map_d = free_map_q;
    dup_d      = dup_q | first_dup | second_dup;
    if (pop_first) begin
      free_map_d[alloc_prd_first_o] = 1'b0;
    end
    if (pop_second) begin
      free_map_d[alloc_prd_second_o] = 1'b0;
    end
    if (push_first) begin
      free_map_d[release_first_prd_i] = 1'b1;
    end
    if (push_second) begin
      free_map_d[release_second_prd_i] = 1'b1;
    end
    if (rst) begin
      for (int i = 0; i < REG_SIZE; i++) begin
        free_map_d[i] = (i >= ARCH_REG_NUM);
      end
      dup_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    free_map_q <= free_map_d;
    dup_q      <= dup_d;
  end

  assign dup_err_o = dup_q;
`else
  assign first_dup  = 1'b0;
  assign second_dup = 1'b0;
  assign dup_err_o  = 1'b0;
`endif

endmodule

// File: doc/physical_freelist.md
# physical_freelist

Physical register free list for the rename/commit unit (RCU). It supplies up to two unused physical destination registers per cycle to rename. It takes back up to two retired stale mappings per cycle from commit. Every register it hands out later becomes a writeback target in `physical_regfile`. It shares that block's `REG_SIZE` and `REG_SIZE_WIDTH` parameters.

## Interface
- `REG_SIZE`, 48: number of physical registers. This is also the circular-buffer depth.
- `REG_SIZE_WIDTH`, 6: width of a physical register index.
- `ARCH_REG_NUM`, 32: architectural registers. At reset, p0..p(ARCH_REG_NUM-1) are mapped and therefore not free.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `alloc_first_i`  in  1  rename consumes the first offered register this cycle.
- `alloc_second_i`  in  1  rename consumes the second offered register this cycle.
- `alloc_prd_first_o`  out  REG_SIZE_WIDTH  register index at head.
- `alloc_prd_second_o`  out  REG_SIZE_WIDTH  register index at head+1 (wrapped).
- `alloc_first_valid_o`  out  1  high when free_count_o >= 1.
- `alloc_second_valid_o`  out  1  high when free_count_o >= 2.
- `release_first_i`  in  1  commit returns `release_first_prd_i`.
- `release_first_prd_i`  in  REG_SIZE_WIDTH  register returned on the first release slot.
- `release_second_i`  in  1  commit returns `release_second_prd_i`.
- `release_second_prd_i`  in  REG_SIZE_WIDTH  register returned on the second release slot.
- `free_count_o`  out  REG_SIZE_WIDTH+1  number of free entries.
- `overflow_err_o`  out  1  sticky flag: a push was dropped because the list was full.
- `dup_err_o`  out  1  sticky flag: a duplicate release was detected (see Configuration).

## Operation
- Storage: circular buffer of REG_SIZE entries, each REG_SIZE_WIDTH bits wide, with `head` and `tail` pointers and a count register.
- Pointer wrap: pointers wrap from REG_SIZE-1 to 0. Pointer arithmetic uses explicit compare-and-wrap, because REG_SIZE need not be a power of two.
- Reset state:
  - entry i = ARCH_REG_NUM+i, for i < REG_SIZE-ARCH_REG_NUM;
  - `head`=0, `tail`=REG_SIZE-ARCH_REG_NUM, count=REG_SIZE-ARCH_REG_NUM;
  - error flags cleared.
- Pop count:
  - pop = (`alloc_first_i` & `alloc_first_valid_o`) + (`alloc_second_i` & `alloc_first_i` & `alloc_second_valid_o`).
  - `alloc_second_i` without `alloc_first_i` is ignored.
  - A request whose valid is low is ignored. It does not underflow.
- Push rules:
  - Push order is the first slot, then the second slot.
  - A release of p0 is ignored, since x0 is never renamed.
  - A push that would make count exceed REG_SIZE is dropped and sets `overflow_err_o`.
- Simultaneous pop and push in one cycle:
  - Both take effect: count_next = count - pop + push.
  - Pops read only entries present before this edge. There is no same-cycle bypass from release to alloc.
- Reset mid-operation restores the full reset state regardless of in-flight requests.

## Timing
- Alloc outputs are combinational reads of the buffer at `head` and `head`+1. They are stable from the clock edge and do not depend on the `alloc_*_i` inputs.
- Pop latency: `head`, count and outputs update at the edge where the pop is accepted. The next offered registers are visible in the following cycle.
- Release latency: a released register is offerable at the earliest in the cycle after the release edge. `free_count_o` reflects the release in that same cycle.
- Reset values of outputs:
  - `alloc_prd_first_o`=ARCH_REG_NUM;
  - `alloc_prd_second_o`=ARCH_REG_NUM+1;
  - both valid outputs=1 (with defaults);
  - `free_count_o`=REG_SIZE-ARCH_REG_NUM;
  - `overflow_err_o`=0, `dup_err_o`=0.

## Configuration
- Macro: `FREELIST_DUP_CHECK_EN`.
- Defined:
  - A REG_SIZE-bit free bitmap is maintained. At reset, bits ARCH_REG_NUM..REG_SIZE-1 are set; pops clear bits and pushes set them.
  - A release of a register whose bit is already set is dropped and sets the sticky `dup_err_o`.
  - If both release slots name the same register, the second slot is dropped and `dup_err_o` is set.
- Undefined: there is no bitmap, every non-p0 release is pushed, and `dup_err_o` is tied 0.

## Test plan
All scenarios use default parameters.
- Reset: after `rst`, `free_count_o`=16, `alloc_prd_first_o`=32, `alloc_prd_second_o`=33, both valids=1.
- Drain: alloc both slots for 8 cycles -> registers 32..47 are returned in order, then `free_count_o`=0 and both valids=0. A further alloc leaves count at 0.
- Refill from empty: release p5 (first) and p9 (second) in one cycle -> next cycle count=2, first=5, second=9.
- Single-slot and odd-request handling:
  - At count=1: `alloc_first_valid_o`=1 and `alloc_second_valid_o`=0.
  - `alloc_second_i` alone -> no pop, count stays 1.
- Simultaneous pop and push at count=2 (offering 5, 9): alloc both and release p20, p21 -> next cycle count=2, offering 20 then 21.
- Illegal releases:
  - Release p0 -> count unchanged.
  - With `FREELIST_DUP_CHECK_EN`, release p40 right after reset -> `dup_err_o`=1 and count stays 16.
